// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - op encodings driven by the E stage (mult/multu/div/divu)
//   - default busy-cycle counts for multiply and divide
//   - sequencer state enum
//   - small decode helper for the op field
// -----------------------------------------------------------------------------
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // op[1] selects the divide family; op[0] selects the unsigned variant.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : md_pkg

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Purely combinational HI:LO result generator for mult/multu/div/divu.
// Ports:
//   op_i          [1:0]  operation (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU)
//   rs_i          [31:0] multiplicand / dividend
//   rt_i          [31:0] multiplier / divisor
//   hilo_o        [63:0] {hi, lo} result (hi = upper product / remainder)
//   div_by_zero_o        divide op with rt == 0; result must not be committed
// -----------------------------------------------------------------------------
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] hilo_o,
  output logic        div_by_zero_o
);

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic        [31:0] rs_mag;
  logic        [31:0] rt_mag;
  logic        [31:0] num;
  logic        [31:0] den;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic        [31:0] quot;
  logic        [31:0] rem;
  logic               signed_div;

  // Full 64-bit products; operands are extended to 64 bits so the low 64 bits
  // of the product are exact for both signednesses.
  assign smul = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign umul = {32'd0, rs_i} * {32'd0, rt_i};

  assign div_by_zero_o = md_is_div(op_i) & (rt_i == 32'd0);
  assign signed_div    = ~op_i[0];

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no
  // special path: |0x80000000| is 0x80000000 as an unsigned value, the
  // unsigned quotient is 0x80000000 and the sign fix-up leaves it untouched.
  // A zero divisor is replaced by 1 only to keep the datapath X-free.
  always_comb begin
    rs_mag = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    rt_mag = rt_i[31] ? (32'd0 - rt_i) : rt_i;
    num    = signed_div ? rs_mag : rs_i;
    if (rt_i == 32'd0) begin
      den = 32'd1;
    end else begin
      den = signed_div ? rt_mag : rt_i;
    end
    q_u  = num / den;
    r_u  = num % den;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    quot = (signed_div && (rs_i[31] ^ rt_i[31])) ? (32'd0 - q_u) : q_u;
    rem  = (signed_div && rs_i[31]) ? (32'd0 - r_u) : r_u;
  end

  // Result select by operation.
  always_comb begin
    hilo_o = 64'd0;
    case (op_i)
      MD_MULT:  hilo_o = smul;
      MD_MULTU: hilo_o = umul;
      MD_DIV:   hilo_o = {rem, quot};
      MD_DIVU:  hilo_o = {rem, quot};
      default:  hilo_o = 64'd0;
    endcase
  end

endmodule : md_arith

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Sequences the shared HI/LO multiply/divide resource of the 5-stage pipeline.
// An accepted mult/div latches its result into pending registers, then holds
// busy for the fixed operation latency before committing to architectural
// HI/LO. mthi/mtlo write HI/LO directly in one cycle when idle.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, op[1:0]      E-stage mult/multu/div/divu issue
//   mt_hi, mt_lo        E-stage mthi/mtlo issue (data on rs_val)
//   rs_val, rt_val      forwarded operands
//   md_use_E            instruction in E uses HI/LO
//   busy                operation in flight (registered)
//   stall_req           freeze PC/D/E: md_use_E & (start | busy)
//   hi, lo              architectural HI/LO (registered)
// -----------------------------------------------------------------------------
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_E,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter load values: the count reaches zero on the last busy cycle.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       hi_p_q,  hi_p_d;
  logic [31:0]       lo_p_q,  lo_p_d;
  logic              dz_p_q,  dz_p_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;
  logic              busy_q,  busy_d;

  logic [63:0]       arith_hilo;
  logic              arith_dz;

  md_arith u_arith (
    .op_i          (op),
    .rs_i          (rs_val),
    .rt_i          (rt_val),
    .hilo_o        (arith_hilo),
    .div_by_zero_o (arith_dz)
  );

  // State register: FSM, counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
      dz_p_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      dz_p_q  <= dz_p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: accept ops/moves in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    dz_p_d  = dz_p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // start has priority over a simultaneous mthi/mtlo.
          {hi_p_d, lo_p_d} = arith_hilo;
          dz_p_d  = arith_dz;
          cnt_d   = md_is_div(op) ? DIV_LOAD : MULT_LOAD;
          state_d = ST_RUN;
        end else begin
          if (mt_hi) begin
            hi_d = rs_val;
          end else begin
            hi_d = hi_q;
          end
          if (mt_lo) begin
            lo_d = rs_val;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // A divide by zero still takes the full latency but leaves HI/LO.
          if (!dz_p_q) begin
            hi_d = hi_p_q;
            lo_d = lo_p_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = md_use_E & (start | busy_q);

endmodule : md_sequencer
